// File: rtl/mul_chunk_seq_if.sv
// Handshake and data bundle between the execute stage and the chunked multiplier.
// The master drives operands and consumes results, and the slave is the multiplier.
interface mul_chunk_seq_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, product
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, product
  );
endinterface

// File: rtl/mul_chunk_seq.sv
// Sequential RV32M-style multiplier. Operands are reduced to magnitudes and cut
// into CHUNK-bit slices. One slice-by-slice partial product is accumulated per
// cycle, and the sign is applied once at the end.
module mul_chunk_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  mul_chunk_seq_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int P  = N * N;
  localparam int KW = (P > 1) ? $clog2(P) : 1;
  localparam int W2 = 2 * WIDTH;
  localparam int C2 = 2 * CHUNK;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_q;
  logic [W2-1:0]    acc;
  logic [KW-1:0]    k;
  logic [W2-1:0]    product_q;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;

  // Operand decode at acceptance. The magnitude of the most negative value still
  // fits in WIDTH bits when it is read as unsigned.
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU);
  assign b_signed = (bus.op == OP_MULH);
  assign a_neg    = a_signed & bus.a[WIDTH-1];
  assign b_neg    = b_signed & bus.b[WIDTH-1];
  assign a_abs    = a_neg ? -bus.a : bus.a;
  assign b_abs    = b_neg ? -bus.b : bus.b;

  // Partial product for step k = i*N + j: |a| slice j times |b| slice i, weighted by CHUNK*(i+j).
  logic [KW-1:0]    i_idx, j_idx;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic [C2-1:0]    pp;
  logic [W2-1:0]    pp_term;
  assign i_idx   = k / KW'(N);
  assign j_idx   = k % KW'(N);
  assign a_sl    = CHUNK'(a_mag >> (CHUNK * int'(j_idx)));
  assign b_sl    = CHUNK'(b_mag >> (CHUNK * int'(i_idx)));
  assign pp      = C2'(a_sl) * C2'(b_sl);
  assign pp_term = W2'(pp) << (CHUNK * (int'(i_idx) + int'(j_idx)));

  // Signed fix-up of the finished magnitude product.
  logic [W2-1:0] prod_fix;
  assign prod_fix = neg_q ? -acc : acc;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. A flush overrides every transition.
  // NOTE: the default assigned first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = CALC;
      CALC:    if (k == KW'(P - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Datapath: latch operands, accumulate partial products, register the result.
  // NOTE: these are plain flops rather than memory, so every one of them is cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_mag       <= '0;
      b_mag       <= '0;
      neg_q       <= 1'b0;
      acc         <= '0;
      k           <= '0;
      product_q   <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q  <= bus.op;
          a_mag <= a_abs;
          b_mag <= b_abs;
          neg_q <= a_neg ^ b_neg;
          acc   <= '0;
          k     <= '0;
        end
        CALC: begin
          acc <= acc + pp_term;
          k   <= (k == KW'(P - 1)) ? '0 : k + KW'(1);
        end
        FIX: begin
          product_q   <= prod_fix;
          result_q    <= (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[W2-1:WIDTH];
          out_valid_q <= 1'b1;
        end
        DONE: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_mul_chunk_seq.sv
// Directed self-checking bench for mul_chunk_seq. It runs a vector table on the
// default 16-bit-chunk instance, plus handshake, flush and reset sequences, and
// a latency check on an 8-bit-chunk instance.
module tb_mul_chunk_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic flush8;

  always #5 clk = ~clk;

  mul_chunk_seq_if #(.WIDTH(W)) bus ();
  mul_chunk_seq_if #(.WIDTH(W)) bus8 ();

  mul_chunk_seq #(.WIDTH(W), .CHUNK(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  mul_chunk_seq #(.WIDTH(W), .CHUNK(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush8),
    .bus   (bus8.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an operation and let it be accepted on the next edge (edge 0).
  // The task returns just after that edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    check("in_ready before accept", 64'(bus.in_ready), 64'd1);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count the edges from acceptance until out_valid is high, with a bound on the wait.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
  endtask

  // Watch for a number of cycles and require that out_valid never rises.
  task automatic watch_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vecs[0]  = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFE_00000001};
    vecs[1]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 64'h40000000_00000000};
    vecs[2]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 64'h00000006_FFFFFFEB};
    vecs[3]  = '{2'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFE};
    vecs[4]  = '{2'd3, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 64'h00000001_FFFFFFFE};
    vecs[5]  = '{2'd1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
    vecs[6]  = '{2'd0, 32'h00000006, 32'h00000007, 32'h0000002A, 64'h00000000_0000002A};
    vecs[7]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 64'h80000000_80000000};
    vecs[8]  = '{2'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 64'h3FFFFFFF_00000001};
    vecs[9]  = '{2'd1, 32'h00000000, 32'h80000000, 32'h00000000, 64'h00000000_00000000};
    vecs[10] = '{2'd0, 32'h00010000, 32'h00010000, 32'h00000000, 64'h00000001_00000000};

    rst_n = 1'b0;
    flush = 1'b0;
    flush8 = 1'b0;
    bus.in_valid = 1'b0;  bus.op = 2'd0;  bus.a = '0;  bus.b = '0;  bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.op = 2'd0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;

    // Reset state.
    #12;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset result", 64'(bus.result), 64'd0);
    check("reset product", bus.product, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("in_ready after reset", 64'(bus.in_ready), 64'd1);

    // Vector table, with the consumer always ready.
    for (int v = 0; v < 11; v++) begin
      issue(vecs[v].op, vecs[v].a, vecs[v].b);
      wait_valid(lat);
      check($sformatf("vec%0d latency", v), 64'(lat), 64'd5);
      check($sformatf("vec%0d result", v), 64'(bus.result), 64'(vecs[v].res));
      check($sformatf("vec%0d product", v), bus.product, vecs[v].prod);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pulse width", v), 64'(bus.out_valid), 64'd0);
      check($sformatf("vec%0d in_ready after", v), 64'(bus.in_ready), 64'd1);
    end

    // Backpressure: hold the result for 3 cycles while a new operand is offered and ignored.
    bus.out_ready = 1'b0;
    issue(2'd3, 32'hFFFFFFFF, 32'h00000002);
    wait_valid(lat);
    check("bp latency", 64'(lat), 64'd5);
    bus.op = 2'd0; bus.a = 32'd5; bus.b = 32'd5; bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("bp out_valid held", 64'(bus.out_valid), 64'd1);
      check("bp result stable", 64'(bus.result), 64'h00000001);
      check("bp product stable", bus.product, 64'h00000001_FFFFFFFE);
      check("bp in_ready low", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp out_valid drop", 64'(bus.out_valid), 64'd0);
    check("bp in_ready back", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0;
    watch_quiet("bp operand not accepted", 8);

    // Flush on the second CALC cycle: no result, and the old outputs are kept.
    issue(2'd0, 32'd6, 32'd7);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush to idle", 64'(bus.in_ready), 64'd1);
    watch_quiet("flush no out_valid", 8);
    check("flush result kept", 64'(bus.result), 64'h00000001);
    check("flush product kept", bus.product, 64'h00000001_FFFFFFFE);
    issue(2'd0, 32'd6, 32'd7);
    wait_valid(lat);
    check("post-flush latency", 64'(lat), 64'd5);
    check("post-flush result", 64'(bus.result), 64'd42);
    @(posedge clk);
    #1;

    // Flush together with in_valid in IDLE: the operands are not accepted.
    bus.op = 2'd0; bus.a = 32'd3; bus.b = 32'd3; bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("idle flush stays idle", 64'(bus.in_ready), 64'd1);
    watch_quiet("idle flush no accept", 8);

    // 8-bit chunks (P=16): out_valid arrives 17 edges after acceptance.
    bus8.op = 2'd0; bus8.a = 32'h0000FFFF; bus8.b = 32'h0000FFFF; bus8.in_valid = 1'b1;
    check("c8 in_ready", 64'(bus8.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus8.out_valid) break;
    end
    check("c8 latency", 64'(lat), 64'd17);
    check("c8 result", 64'(bus8.result), 64'hFFFE0001);
    check("c8 product high", 64'(bus8.product[63:32]), 64'd0);

    // Reset pulse in mid-CALC clears everything at once.
    issue(2'd0, 32'd6, 32'd5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst mid out_valid", 64'(bus.out_valid), 64'd0);
    check("rst mid result", 64'(bus.result), 64'd0);
    check("rst mid product", bus.product, 64'd0);
    check("rst mid in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(2'd0, 32'd6, 32'd7);
    wait_valid(lat);
    check("post-reset latency", 64'(lat), 64'd5);
    check("post-reset result", 64'(bus.result), 64'd42);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
